// File: rtl/pio_edge_poll_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pio_edge_poll_pkg: shared state encoding and slave register map.  Rev 1.0
// ----------------------------------------------------------------------------
package pio_edge_poll_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_IDLE      = 3'd1,
    ST_RD_EDGE   = 3'd2,
    ST_WAIT_EDGE = 3'd3,
    ST_CLR       = 3'd4,
    ST_RD_LVL    = 3'd5,
    ST_WAIT_LVL  = 3'd6
  } state_e;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/pio_edge_poll_master_poll_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// poll_timer: reload down-counter emitting a 1-cycle tick every POLL_DIV clks.  Rev 1.0
// ----------------------------------------------------------------------------
module poll_timer #(
  parameter int unsigned POLL_DIV = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tick_o
);

  generate
    if (POLL_DIV == 0) begin : g_off
      logic w_unused_in;
      assign w_unused_in = ^{clk, reset_n, en_i};
      assign tick_o      = 1'b0;
    end else begin : g_on
      localparam int unsigned   CW     = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
      localparam logic [CW-1:0] RELOAD = CW'(POLL_DIV - 1);

      logic [CW-1:0] cnt_q, cnt_d;
      logic          w_zero;

      assign w_zero = (cnt_q == '0);

      always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
          cnt_d = w_zero ? RELOAD : (cnt_q - CW'(1));
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= RELOAD;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign tick_o = en_i & w_zero;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pio_edge_poll_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pio_edge_poll_master: Avalon-MM master servicing an edge-capture PIO.  Rev 1.0
// ----------------------------------------------------------------------------
module pio_edge_poll_master
  import pio_edge_poll_pkg::*;
#(
  parameter int unsigned IRQ_MASK = 1,
  parameter int unsigned POLL_DIV = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             event_pulse,
  output logic [CNT_W-1:0] event_count,
  output logic             level,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [2:0]       sync_q;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             level_q, level_d;

  logic             w_tick, w_irq_rise, w_trigger;
  logic             w_cs, w_wn, w_pulse;
  logic [1:0]       w_addr;
  logic [31:0]      w_wd;
  logic [30:0]      w_unused_rdata;

  assign w_unused_rdata = avm_readdata[31:1];

  poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_poll_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (1'b1),
    .tick_o  (w_tick)
  );

  // sync_q[1] is the synchronised irq, sync_q[2] its previous value.
  assign w_irq_rise = sync_q[1] & ~sync_q[2];
  assign w_trigger  = w_irq_rise | w_tick;
  assign pending_d  = w_trigger | (pending_q & (state_q != ST_RD_EDGE));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    w_cs    = 1'b0;
    w_wn    = 1'b1;
    w_addr  = ADDR_DATA;
    w_wd    = '0;
    w_pulse = 1'b0;
    case (state_q)
      ST_INIT: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = ADDR_MASK;
        w_wd    = 32'(IRQ_MASK);
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pending_q) state_d = ST_RD_EDGE;
      end
      ST_RD_EDGE: begin
        w_cs    = 1'b1;
        w_addr  = ADDR_EDGE;
        state_d = ST_WAIT_EDGE;
      end
      ST_WAIT_EDGE: begin
        w_addr  = ADDR_EDGE;
        state_d = avm_readdata[0] ? ST_CLR : ST_RD_LVL;
      end
      ST_CLR: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = ADDR_EDGE;
        w_pulse = 1'b1;
        count_d = count_q + CNT_W'(1);
        state_d = ST_RD_LVL;
      end
      ST_RD_LVL: begin
        w_cs    = 1'b1;
        state_d = ST_WAIT_LVL;
      end
      ST_WAIT_LVL: begin
        level_d = avm_readdata[0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_INIT;
      sync_q    <= '0;
      pending_q <= 1'b0;
      count_q   <= '0;
      level_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], irq};
      pending_q <= pending_d;
      count_q   <= count_d;
      level_q   <= level_d;
    end
  end

  // State resets to INIT, whose decode is a write; mask the bus while in reset.
  assign avm_chipselect = reset_n & w_cs;
  assign avm_write_n    = ~reset_n | w_wn;
  assign avm_address    = reset_n ? w_addr : ADDR_DATA;
  assign avm_writedata  = reset_n ? w_wd : '0;
  assign event_pulse    = reset_n & w_pulse;
  assign event_count    = count_q;
  assign level          = level_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pio_edge_poll_master.sv
`default_nettype none
// Bench: two masters (irq-only 16-bit count, polled 4-bit count) against PIO slave models.
module tb_pio_edge_poll_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- DUT A: irq-only, 16-bit count ----------------
  logic        rst_a_n = 1'b0;
  logic        irq_force_a = 1'b0;
  logic        irq_a;
  logic [1:0]  addr_a;
  logic        cs_a, wn_a, pulse_a, lvl_a, busy_a;
  logic [31:0] wd_a;
  logic [31:0] rd_a = 32'd0;
  logic [15:0] cnt_a;
  logic        btn_a = 1'b1, btn_a_prev = 1'b1, edge_a = 1'b0, mask_a = 1'b0;

  assign irq_a = (edge_a & mask_a) | irq_force_a;

  pio_edge_poll_master #(.IRQ_MASK(1), .POLL_DIV(0), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset_n(rst_a_n), .irq(irq_a),
    .avm_address(addr_a), .avm_chipselect(cs_a), .avm_write_n(wn_a),
    .avm_writedata(wd_a), .avm_readdata(rd_a),
    .event_pulse(pulse_a), .event_count(cnt_a), .level(lvl_a), .busy(busy_a)
  );

  always @(posedge clk) begin
    btn_a_prev <= btn_a;
    case (addr_a)
      2'd0:    rd_a <= {31'd0, btn_a};
      2'd2:    rd_a <= {31'd0, mask_a};
      2'd3:    rd_a <= {31'd0, edge_a};
      default: rd_a <= 32'd0;
    endcase
    if (cs_a && !wn_a && addr_a == 2'd2) mask_a <= wd_a[0];
    if (cs_a && !wn_a && addr_a == 2'd3) edge_a <= 1'b0;
    else if (btn_a_prev && !btn_a)       edge_a <= 1'b1;
  end

  // ---------------- DUT B: polled every 8, 4-bit count, mask 0 ----------------
  logic        rst_b_n = 1'b0;
  logic        irq_b;
  logic [1:0]  addr_b;
  logic        cs_b, wn_b, pulse_b, lvl_b, busy_b;
  logic [31:0] wd_b;
  logic [31:0] rd_b = 32'd0;
  logic [3:0]  cnt_b;
  logic        btn_b = 1'b1, btn_b_prev = 1'b1, edge_b = 1'b0, mask_b = 1'b1;
  int          pulses_b = 0;

  assign irq_b = edge_b & mask_b;

  pio_edge_poll_master #(.IRQ_MASK(0), .POLL_DIV(8), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset_n(rst_b_n), .irq(irq_b),
    .avm_address(addr_b), .avm_chipselect(cs_b), .avm_write_n(wn_b),
    .avm_writedata(wd_b), .avm_readdata(rd_b),
    .event_pulse(pulse_b), .event_count(cnt_b), .level(lvl_b), .busy(busy_b)
  );

  always @(posedge clk) begin
    btn_b_prev <= btn_b;
    case (addr_b)
      2'd0:    rd_b <= {31'd0, btn_b};
      2'd2:    rd_b <= {31'd0, mask_b};
      2'd3:    rd_b <= {31'd0, edge_b};
      default: rd_b <= 32'd0;
    endcase
    if (cs_b && !wn_b && addr_b == 2'd2) mask_b <= wd_b[0];
    if (cs_b && !wn_b && addr_b == 2'd3) edge_b <= 1'b0;
    else if (btn_b_prev && !btn_b)       edge_b <= 1'b1;
    if (pulse_b) pulses_b <= pulses_b + 1;
  end

  int exp_cnt_a = 0;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    step(3);
    #1;
    n_vec++;
    if ({cs_a, wn_a, addr_a, wd_a, pulse_a, busy_a, lvl_a, cnt_a} !==
        {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_a: got cs=%b wn=%b addr=%0d wd=%h pulse=%b busy=%b lvl=%b cnt=%h, want 0 1 0 0 0 1 0 0",
               cs_a, wn_a, addr_a, wd_a, pulse_a, busy_a, lvl_a, cnt_a);
    end
    n_vec++;
    if ({cs_b, wn_b, addr_b, wd_b, pulse_b, busy_b, lvl_b, cnt_b} !==
        {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_b: got cs=%b wn=%b addr=%0d wd=%h pulse=%b busy=%b lvl=%b cnt=%h, want 0 1 0 0 0 1 0 0",
               cs_b, wn_b, addr_b, wd_b, pulse_b, busy_b, lvl_b, cnt_b);
    end
    @(negedge clk);
    rst_a_n = 1'b1;
    #1;
    n_vec++;
    if ({cs_a, wn_a, addr_a, wd_a, busy_a} !== {1'b1, 1'b0, 2'd2, 32'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL init_write_a: got cs=%b wn=%b addr=%0d wd=%h busy=%b, want 1 0 2 00000001 1",
               cs_a, wn_a, addr_a, wd_a, busy_a);
    end
    @(negedge clk);
    n_vec++;
    if ({cs_a, wn_a, addr_a, busy_a, mask_a} !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL idle_after_init_a: got cs=%b wn=%b addr=%0d busy=%b mask=%b, want 0 1 0 0 1",
               cs_a, wn_a, addr_a, busy_a, mask_a);
    end
    exp_cnt_a = 0;
  endtask

  // Bus view {busy, cs, write_n, address, pulse} i cycles after the button falls.
  function automatic logic [5:0] edge_txn_view(input int i);
    case (i)
      5:       return {1'b1, 1'b1, 1'b1, 2'd3, 1'b0};
      6:       return {1'b1, 1'b0, 1'b1, 2'd3, 1'b0};
      7:       return {1'b1, 1'b1, 1'b0, 2'd3, 1'b1};
      8:       return {1'b1, 1'b1, 1'b1, 2'd0, 1'b0};
      9:       return {1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
      default: return {1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    endcase
  endfunction

  task automatic test_irq_edge();
    int         k;
    logic       exp_lvl;
    logic [5:0] obs, exp;
    for (int it = 0; it < 4; it++) begin
      k       = $urandom_range(1, 10);
      exp_lvl = (k <= 8);
      btn_a   = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        obs = {busy_a, cs_a, wn_a, addr_a, pulse_a};
        exp = edge_txn_view(i);
        n_vec++;
        if (obs !== exp) begin
          n_bad++;
          $display("FAIL irq_edge it%0d cyc%0d: got bus %b, want %b", it, i, obs, exp);
        end
        if (i == 7) begin
          n_vec++;
          if (wd_a !== 32'd0) begin
            n_bad++;
            $display("FAIL clr_data it%0d: got %h, want 0", it, wd_a);
          end
        end
        if (i == k) btn_a = 1'b1;
      end
      exp_cnt_a++;
      n_vec++;
      if ({lvl_a, cnt_a, edge_a} !== {exp_lvl, 16'(exp_cnt_a), 1'b0}) begin
        n_bad++;
        $display("FAIL irq_edge_result it%0d: got lvl=%b cnt=%h edge=%b, want lvl=%b cnt=%h edge=0",
                 it, lvl_a, cnt_a, edge_a, exp_lvl, 16'(exp_cnt_a));
      end
      btn_a = 1'b1;
      step($urandom_range(3, 6));
    end
  endtask

  task automatic test_back_to_back();
    logic rd, wr, exp_rd;
    irq_force_a = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      rd     = cs_a & wn_a & (addr_a == 2'd3);
      wr     = cs_a & ~wn_a;
      exp_rd = (i == 4) || (i == 9);
      n_vec++;
      if ({rd, wr} !== {exp_rd, 1'b0}) begin
        n_bad++;
        $display("FAIL back_to_back cyc%0d: got rd=%b wr=%b, want rd=%b wr=0", i, rd, wr, exp_rd);
      end
      irq_force_a = (i == 2) || (i == 4) || (i == 6);
    end
    n_vec++;
    if ({lvl_a, cnt_a, busy_a} !== {1'b1, 16'(exp_cnt_a), 1'b0}) begin
      n_bad++;
      $display("FAIL back_to_back_end: got lvl=%b cnt=%h busy=%b, want 1 %h 0",
               lvl_a, cnt_a, busy_a, 16'(exp_cnt_a));
    end
  endtask

  task automatic test_poll();
    logic rd, wr, exp_rd;
    rst_b_n = 1'b1;
    #1;
    n_vec++;
    if ({cs_b, wn_b, addr_b, wd_b} !== {1'b1, 1'b0, 2'd2, 32'd0}) begin
      n_bad++;
      $display("FAIL init_write_b: got cs=%b wn=%b addr=%0d wd=%h, want 1 0 2 00000000",
               cs_b, wn_b, addr_b, wd_b);
    end
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      rd     = cs_b & wn_b & (addr_b == 2'd3);
      wr     = cs_b & ~wn_b;
      exp_rd = (i >= 9) && (((i - 9) % 8) == 0);
      n_vec++;
      if ({rd, wr} !== {exp_rd, 1'b0}) begin
        n_bad++;
        $display("FAIL poll cyc%0d: got rd=%b wr=%b, want rd=%b wr=0", i, rd, wr, exp_rd);
      end
    end
    n_vec++;
    if ({cnt_b, mask_b} !== {4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL poll_end: got cnt=%h mask=%b, want cnt=0 mask=0", cnt_b, mask_b);
    end
  endtask

  task automatic test_wrap();
    int p0;
    for (int k = 0; k < 17; k++) begin
      p0    = pulses_b;
      btn_b = 1'b0;
      step($urandom_range(8, 11));
      btn_b = 1'b1;
      step($urandom_range(10, 13));
      n_vec++;
      if ({cnt_b, 4'(pulses_b - p0)} !== {4'((k + 1) % 16), 4'd1}) begin
        n_bad++;
        $display("FAIL wrap edge%0d: got cnt=%h pulses=%0d, want cnt=%h pulses=1",
                 k, cnt_b, pulses_b - p0, 4'((k + 1) % 16));
      end
    end
  endtask

  task automatic test_reset_mid();
    btn_a = 1'b0;
    step(7);
    n_vec++;
    if ({cs_a, wn_a, addr_a, pulse_a} !== {1'b1, 1'b0, 2'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_clr: got cs=%b wn=%b addr=%0d pulse=%b, want 1 0 3 1", cs_a, wn_a, addr_a, pulse_a);
    end
    rst_a_n = 1'b0;
    #1;
    n_vec++;
    if ({cs_a, wn_a, addr_a, wd_a, pulse_a, busy_a, lvl_a, cnt_a} !==
        {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: got cs=%b wn=%b addr=%0d wd=%h pulse=%b busy=%b lvl=%b cnt=%h, want 0 1 0 0 0 1 0 0",
               cs_a, wn_a, addr_a, wd_a, pulse_a, busy_a, lvl_a, cnt_a);
    end
    @(negedge clk);
    rst_a_n = 1'b1;
    #1;
    n_vec++;
    if ({cs_a, wn_a, addr_a, wd_a} !== {1'b1, 1'b0, 2'd2, 32'd1}) begin
      n_bad++;
      $display("FAIL reinit_write: got cs=%b wn=%b addr=%0d wd=%h, want 1 0 2 00000001", cs_a, wn_a, addr_a, wd_a);
    end
    btn_a = 1'b1;
    step(20);
    // The uncleared edge re-raises irq after reset and is serviced once.
    n_vec++;
    if ({cnt_a, edge_a, busy_a} !== {16'd1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL after_reinit: got cnt=%h edge=%b busy=%b, want cnt=0001 edge=0 busy=0", cnt_a, edge_a, busy_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_irq_edge();
    test_back_to_back();
    test_poll();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pio_edge_poll_master.md
# pio_edge_poll_master

Avalon-MM master that services a single-bit edge-capturing input PIO slave, such as the harp's button PIO. On an irq rising edge or a poll-timer expiry it reads the slave's edge-capture register. If an edge was captured, it clears the register, pulses an event and counts it. It then reads the live input level. The block lets fabric logic consume button events without the HPS.

## Interface
Parameters:
- IRQ_MASK, 1: value written to slave address 2 (irq mask) after reset.
- POLL_DIV, 0: poll period in clk cycles; 0 disables timed polling (irq-only).
- CNT_W, 16: width of event_count.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- irq  in  1  slave irq (level, asynchronous to this logic).
- avm_address  out  2  slave register select.
- avm_chipselect  out  1  slave select.
- avm_write_n  out  1  active-low write strobe.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  slave read data; only bit 0 is used.
- event_pulse  out  1  one-cycle pulse per serviced edge.
- event_count  out  CNT_W  number of serviced edges.
- level  out  1  last sampled live input (slave address 0, bit 0).
- busy  out  1  high in every state except IDLE.

## Operation
- Slave contract: no waitrequest. A write completes in the cycle it is driven. The slave registers readdata every clk from the current address, so data for the address driven in cycle N is valid in cycle N+1.
- The Avalon outputs and event_pulse decode directly from the state register. Outside write states: chipselect 0, write_n 1, writedata 0.
- States:
  - INIT: chipselect 1, write_n 0, address 2, writedata = IRQ_MASK. Next state IDLE.
  - IDLE: address 0. Goes to RD_EDGE when pending = 1.
  - RD_EDGE: chipselect 1, address 3. Clears pending.
  - WAIT_EDGE: address 3. Samples readdata[0] into edge_flag. Goes to CLR if edge_flag = 1, else to RD_LVL.
  - CLR: chipselect 1, write_n 0, address 3, writedata 0. Asserts event_pulse and increments event_count. Next state RD_LVL.
  - RD_LVL: chipselect 1, address 0.
  - WAIT_LVL: address 0. Samples readdata[0] into level. Next state IDLE.
- Triggers:
  - irq passes through a 2-flop synchroniser; a rising edge of the synchronised signal sets pending.
  - The poll timer counts POLL_DIV-1 down to 0, sets pending at 0, then reloads. The timer runs continuously, including while busy.
- A trigger arriving while busy sets pending again, so exactly one further transaction runs after WAIT_LVL. Multiple triggers in one busy window collapse into one transaction.
- event_count wraps modulo 2^CNT_W.
- Accepted race: an edge that the slave detects in the CLR cycle is lost, because the slave gives clear priority. An edge detected between WAIT_EDGE and CLR is absorbed by the clear and is not counted again.

## Timing
- Reset values:
  - state INIT, pending 0, timer POLL_DIV-1, synchroniser 0.
  - event_count 0, level 0, event_pulse 0, busy 1 (INIT).
  - avm_address 0, avm_chipselect 0, avm_write_n 1, avm_writedata 0 while reset_n is low.
- INIT lasts exactly 1 cycle after reset deasserts.
- irq rising at the pins: pending is set 3 cycles later (2 synchroniser flops plus the edge register). RD_EDGE follows on the next cycle.
- With RD_EDGE at cycle N:
  - Edge captured: CLR with event_pulse at N+2, level updated at end of N+4, IDLE at N+5.
  - No edge: level updated at end of N+3, IDLE at N+4.
- Minimum spacing between consecutive RD_EDGE cycles: 6 cycles (edge captured) or 5 cycles (no edge).
- Trigger and pending-clear in the same cycle (RD_EDGE): set wins.
- reset_n asserted mid-transaction: all outputs go to reset values immediately. INIT repeats after reset deasserts.

## Structure
- Package pio_edge_poll_pkg holds:
  - state enum.
  - slave address constants: ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3.
- One natural sub-module, poll_timer: reload down-counter with enable, driven by POLL_DIV, producing a 1-cycle tick. The synchroniser and FSM stay in the top level.

## Test plan
Bench uses a behavioural model of the edge-capturing PIO slave.
- Reset release -> single write: address 2, writedata 1, one cycle; then IDLE with busy 0.
- Button falling edge (slave edge_capture = 1), irq rise -> sequence RD_EDGE, WAIT_EDGE, CLR (write address 3, data 0), RD_LVL, WAIT_LVL. Required: one event_pulse, event_count 0 -> 1, slave edge_capture = 0, level = 0.
- POLL_DIV = 8 with no edges -> RD_EDGE every 8 cycles; no write cycles; event_count stays 0.
- Two irq rises inside one busy window -> exactly one extra transaction; no third.
- Start event_count at 0xFFFF (CNT_W = 16), service one edge -> count wraps to 0x0000 and event_pulse fires.
- reset_n pulsed low during CLR -> outputs take reset values within the reset cycle; event_count 0; INIT write reissued after release.
